// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline has priority, LU results are buffered and drained in idle cycles.
// Latency: pipeline 1 cycle, LU >= 2 cycles; LU back-pressured by o_lu_ready (FIFO full), pipeline by a one-cycle o_pipe_stall on starvation.
module wb_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wb_wen,
  input  logic [4:0]            i_wb_addr,
  input  logic [DATA_WIDTH-1:0] i_wb_data,
  input  logic                  i_lu_valid,
  output logic                  o_lu_ready,
  input  logic [4:0]            i_lu_addr,
  input  logic [DATA_WIDTH-1:0] i_lu_data,
  output logic                  o_pipe_stall,
  output logic                  o_rd_wen,
  output logic [4:0]            o_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_wdata
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [7:0]  LIMIT_C = 8'(STARVE_LIMIT);

  logic [4:0]            fifo_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           count, count_nxt;
  logic [7:0]            starve_cnt, starve_nxt;
  logic                  stall_nxt;
  logic                  fifo_empty, push, pop, sel_pipe, pipe_req;

  assign fifo_empty = (count == '0);
  assign o_lu_ready = (count != DEPTH_C);
  assign pipe_req   = i_wb_wen && (i_wb_addr != 5'd0);
  // x0 results complete the handshake but never occupy a slot
  assign push       = i_lu_valid && o_lu_ready && (i_lu_addr != 5'd0);

  always_comb begin
    pop      = 1'b0;
    sel_pipe = 1'b0;
    if (o_pipe_stall) begin
      pop = !fifo_empty;
    end else if (pipe_req) begin
      sel_pipe = 1'b1;
    end else begin
      pop = !fifo_empty;
    end
  end

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (pop || fifo_empty) begin
      starve_nxt = 8'd0;
    end else if (starve_cnt != LIMIT_C) begin
      starve_nxt = starve_cnt + 8'd1;
    end
    // stall is raised on the edge the counter saturates, and always drops after one cycle
    stall_nxt = !o_pipe_stall && (starve_nxt == LIMIT_C);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= i_lu_addr;
      fifo_data[wr_ptr] <= i_lu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      starve_cnt   <= 8'd0;
      o_pipe_stall <= 1'b0;
      o_rd_wen     <= 1'b0;
      o_rd_addr    <= 5'd0;
      o_rd_wdata   <= '0;
    end else begin
      count        <= count_nxt;
      starve_cnt   <= starve_nxt;
      o_pipe_stall <= stall_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (sel_pipe) begin
        o_rd_wen   <= 1'b1;
        o_rd_addr  <= i_wb_addr;
        o_rd_wdata <= i_wb_data;
      end else if (pop) begin
        o_rd_wen   <= 1'b1;
        o_rd_addr  <= fifo_addr[rd_ptr];
        o_rd_wdata <= fifo_data[rd_ptr];
      end else begin
        o_rd_wen   <= 1'b0;
        o_rd_addr  <= 5'd0;
        o_rd_wdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: reset, a vector table for single-cycle behaviour, and sequences for starvation and reset.
module tb_wb_arbiter;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
  localparam int NV    = 13;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_wb_wen, i_lu_valid, o_lu_ready, o_pipe_stall, o_rd_wen;
  logic [4:0]    i_wb_addr, i_lu_addr, o_rd_addr;
  logic [DW-1:0] i_wb_data, i_lu_data, o_rd_wdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t sb[$];
  wr_t mon_e;

  typedef struct {
    logic        wb_wen;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic        e_wen;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_ready;
  } vec_t;
  vec_t vecs[NV];

  wb_arbiter #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_wb_wen     (i_wb_wen),
    .i_wb_addr    (i_wb_addr),
    .i_wb_data    (i_wb_data),
    .i_lu_valid   (i_lu_valid),
    .o_lu_ready   (o_lu_ready),
    .i_lu_addr    (i_lu_addr),
    .i_lu_data    (i_lu_data),
    .o_pipe_stall (o_pipe_stall),
    .o_rd_wen     (o_rd_wen),
    .o_rd_addr    (o_rd_addr),
    .o_rd_wdata   (o_rd_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_wb_wen = 1'b0; i_wb_addr = 5'd0; i_wb_data = '0;
    i_lu_valid = 1'b0; i_lu_addr = 5'd0; i_lu_data = '0;
  endtask

  function automatic vec_t mk(input logic ww, input logic [4:0] wa, input logic [31:0] wd,
                              input logic lv, input logic [4:0] la, input logic [31:0] ld,
                              input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                              input logic er);
    vec_t v;
    v.wb_wen = ww; v.wb_addr = wa; v.wb_data = wd;
    v.lu_valid = lv; v.lu_addr = la; v.lu_data = ld;
    v.e_wen = ew; v.e_addr = ea; v.e_data = ed; v.e_ready = er;
    return v;
  endfunction

  // Every write reaching the regfile must match the next expected entry, in order.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && o_rd_wen === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got write addr %0d data 0x%0h, expected no write", o_rd_addr, o_rd_wdata);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_addr", 32'(o_rd_addr), 32'(mon_e.addr));
        chk("sb_data", o_rd_wdata, mon_e.data);
      end
    end
  end

  // A pipeline write while stalled is a protocol violation by the core.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && o_pipe_stall === 1'b1 && i_wb_wen === 1'b1 && i_wb_addr != 5'd0) begin
      errors++;
      $display("FAIL stall_contract: got pipeline write to x%0d during stall, expected none", i_wb_addr);
    end
  end

  initial begin
    //           wb_wen addr data            lu_v addr data       e_wen addr data            ready
    vecs[0]  = mk(1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,    1, 5'd5,  32'hDEADBEEF, 1);
    vecs[1]  = mk(1, 5'd0,  32'h11111111, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,        1);
    vecs[2]  = mk(0, 5'd0,  32'h0,        1, 5'd7,  32'h1234, 0, 5'd0,  32'h0,        1);
    vecs[3]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    1, 5'd7,  32'h1234,     1);
    vecs[4]  = mk(0, 5'd0,  32'h0,        1, 5'd0,  32'h5555, 0, 5'd0,  32'h0,        1);
    vecs[5]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    0, 5'd0,  32'h0,        1);
    vecs[6]  = mk(1, 5'd3,  32'hAAAA0001, 1, 5'd9,  32'hA,    1, 5'd3,  32'hAAAA0001, 1);
    vecs[7]  = mk(1, 5'd4,  32'hAAAA0002, 1, 5'd10, 32'hB,    1, 5'd4,  32'hAAAA0002, 0);
    vecs[8]  = mk(1, 5'd6,  32'hAAAA0003, 1, 5'd11, 32'hC,    1, 5'd6,  32'hAAAA0003, 0);
    vecs[9]  = mk(0, 5'd0,  32'h0,        1, 5'd11, 32'hC,    1, 5'd9,  32'hA,        1);
    vecs[10] = mk(0, 5'd0,  32'h0,        1, 5'd11, 32'hC,    1, 5'd10, 32'hB,        1);
    vecs[11] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    1, 5'd11, 32'hC,        1);
    vecs[12] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    0, 5'd0,  32'h0,        1);

    // Reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_wb_wen = 1'($urandom); i_wb_addr = 5'($urandom); i_wb_data = $urandom;
      i_lu_valid = 1'($urandom); i_lu_addr = 5'($urandom); i_lu_data = $urandom;
      step();
      chk("rst_wen", 32'(o_rd_wen), 0);
      chk("rst_addr", 32'(o_rd_addr), 0);
      chk("rst_wdata", o_rd_wdata, 0);
      chk("rst_stall", 32'(o_pipe_stall), 0);
      chk("rst_ready", 32'(o_lu_ready), 1);
    end
    idle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_wen", 32'(o_rd_wen), 0);
    end

    // Vector table
    for (int i = 0; i < NV; i++) begin
      i_wb_wen = vecs[i].wb_wen; i_wb_addr = vecs[i].wb_addr; i_wb_data = vecs[i].wb_data;
      i_lu_valid = vecs[i].lu_valid; i_lu_addr = vecs[i].lu_addr; i_lu_data = vecs[i].lu_data;
      if (vecs[i].e_wen) sb.push_back('{vecs[i].e_addr, vecs[i].e_data});
      step();
      chk($sformatf("v%0d_wen", i), 32'(o_rd_wen), 32'(vecs[i].e_wen));
      if (vecs[i].e_wen) begin
        chk($sformatf("v%0d_addr", i), 32'(o_rd_addr), 32'(vecs[i].e_addr));
        chk($sformatf("v%0d_data", i), o_rd_wdata, vecs[i].e_data);
      end
      chk($sformatf("v%0d_ready", i), 32'(o_lu_ready), 32'(vecs[i].e_ready));
      chk($sformatf("v%0d_stall", i), 32'(o_pipe_stall), 0);
    end
    idle();
    step();

    // Starvation: one LU entry, pipeline writes every cycle it is allowed to
    for (int i = 0; i < 9; i++) begin
      if (o_pipe_stall) begin
        i_wb_wen = 1'b0;
        sb.push_back('{5'd12, 32'h77});
      end else begin
        i_wb_wen = 1'b1;
        sb.push_back('{5'(20 + i), 32'hC0DE0000 + 32'(i)});
      end
      i_wb_addr = 5'(20 + i);
      i_wb_data = 32'hC0DE0000 + 32'(i);
      i_lu_valid = (i == 0);
      i_lu_addr = 5'd12;
      i_lu_data = 32'h77;
      step();
      chk($sformatf("starve_stall_c%0d", i + 1), 32'(o_pipe_stall), 32'(i + 1 == 5));
      if (i == 5) chk("starve_lu_addr", 32'(o_rd_addr), 32'd12);
    end
    idle();
    step();
    step();

    // Reset mid-operation discards the buffered LU entry
    i_wb_wen = 1'b1; i_wb_addr = 5'd2; i_wb_data = 32'h22222222;
    i_lu_valid = 1'b1; i_lu_addr = 5'd13; i_lu_data = 32'h13;
    sb.push_back('{5'd2, 32'h22222222});
    step();
    i_lu_valid = 1'b0;
    i_wb_addr = 5'd3; i_wb_data = 32'h33333333;
    sb.push_back('{5'd3, 32'h33333333});
    step();
    #6;
    idle();
    rst_n = 1'b0;
    #1;
    chk("midrst_wen", 32'(o_rd_wen), 0);
    chk("midrst_ready", 32'(o_lu_ready), 1);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("midrst_no_write", 32'(o_rd_wen), 0);
    end

    chk("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
